// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a NUM_DIGITS common-anode 7-segment
//   display. A packed BCD word is double-buffered (pending -> display at each
//   frame boundary) and digits are scanned one slot at a time. Each slot is
//   REFRESH_DIV cycles: BLANK_CYCLES with all anodes off, then the digit's
//   anode driven low for the rest of the slot.
//
//   Optional build macro: SEG7_LZ_SUPPRESS_EN
//     When defined, a digit k > 0 whose nibble and all higher nibbles are
//     zero keeps its anode off for the whole slot. Slot timing and digit_idx
//     progression are unaffected. Digit 0 is always shown.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       1 = scanning, 0 = display dark (returns to IDLE)
//   load         1-cycle strobe, captures bcd_in into the pending buffer
//   bcd_in       packed BCD, digit 0 in bits [3:0]
//   bcd_out      nibble of the current digit (to bcd_to_7segment)
//   an_n         active-low anode enables, one-hot-low or all-high
//   digit_idx    index of the current digit
//   frame_start  1-cycle pulse when digit 0's slot begins
//   bcd_err      1 while the presented nibble is above 9

module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start,
    output logic                          bcd_err
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned BUF_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx_n;
    logic [NUM_DIGITS-1:0]   an_n_n;
    logic [3:0]              bcd_n;
    logic                    err_n;
    logic                    fs_n;
    logic [BUF_W-1:0]        disp_q, disp_n;
    logic [BUF_W-1:0]        pend_q, pend_n;
    logic                    pv_q, pv_n;
    logic                    boundary;
    logic                    slot_start;

    // Select nibble idx out of a packed BCD word.
    function automatic logic [3:0] nibble_at(input logic [BUF_W-1:0] word,
                                             input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        nib = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib = word[4*i +: 4];
            end
        end
        return nib;
    endfunction

    // One-hot-low anode pattern for digit idx.
    function automatic logic [NUM_DIGITS-1:0] digit_mask(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] mask;
        mask = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

`ifdef SEG7_LZ_SUPPRESS_EN
    // Walks from the top digit down, tracking whether every digit seen so far
    // is zero; digit idx is dark when that still holds on reaching it.
    // The loop stops at 1, so digit 0 is never dark.
    function automatic logic lz_dark(input logic [BUF_W-1:0] word,
                                     input logic [IDX_W-1:0] idx);
        logic zero_above;
        logic dark;
        zero_above = 1'b1;
        dark       = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (word[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                dark = zero_above;
            end
        end
        return dark;
    endfunction
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = digit_idx;
        an_n_n     = '1;
        bcd_n      = bcd_out;
        err_n      = bcd_err;
        fs_n       = 1'b0;
        disp_n     = disp_q;
        pend_n     = pend_q;
        pv_n       = pv_q;
        boundary   = 1'b0;
        slot_start = 1'b0;

        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n    = BLANK;
                    cnt_n      = '0;
                    idx_n      = '0;
                    boundary   = 1'b1;
                    slot_start = 1'b1;
                end
                BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_n = SHOW;
`ifdef SEG7_LZ_SUPPRESS_EN
                        an_n_n  = lz_dark(disp_q, digit_idx) ? '1 : digit_mask(digit_idx);
`else
                        an_n_n  = digit_mask(digit_idx);
`endif
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        state_n    = BLANK;
                        cnt_n      = '0;
                        slot_start = 1'b1;
                        if (digit_idx == IDX_LAST) begin
                            idx_n    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_n = digit_idx + 1'b1;
                        end
                    end else begin
                        cnt_n  = cnt + 1'b1;
                        an_n_n = an_n;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end

        // The boundary copy uses the pending value from before this cycle's
        // load, so a coincident load waits for the following frame.
        if (boundary) begin
            fs_n = 1'b1;
            if (pv_q) begin
                disp_n = pend_q;
                pv_n   = 1'b0;
            end
        end
        if (load) begin
            pend_n = bcd_in;
            pv_n   = 1'b1;
        end

        // bcd_out only moves at slot entry; the display buffer is frame-stable.
        if (slot_start) begin
            bcd_n = nibble_at(disp_n, idx_n);
            err_n = (bcd_n > 4'd9);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit_idx   <= '0;
            an_n        <= '1;
            bcd_out     <= '0;
            bcd_err     <= 1'b0;
            frame_start <= 1'b0;
            disp_q      <= '0;
            pend_q      <= '0;
            pv_q        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            digit_idx   <= idx_n;
            an_n        <= an_n_n;
            bcd_out     <= bcd_n;
            bcd_err     <= err_n;
            frame_start <= fs_n;
            disp_q      <= disp_n;
            pend_q      <= pend_n;
            pv_q        <= pv_n;
        end
    end

endmodule
